// File: rtl/stopwatch_pkg.sv
// Shared encodings, BCD constants and width helper for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_PAUSE = 3'd2;
  localparam state_t ST_STEP  = 3'd3;
  localparam state_t ST_HOLD  = 3'd4;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with single-cycle ripple carry and wrap pulse.
module bcd_counter import stopwatch_pkg::*; #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [BCD_W*DIGITS-1:0]   value,
  output logic [BCD_W*DIGITS-1:0]   value_nxt_c,
  output logic                      wrap_c
);

  logic [BCD_W*DIGITS-1:0] sum;
  logic                    carry;

  // Ripple the increment through every digit within one cycle.
  always_comb begin
    sum   = value;
    carry = inc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (carry) begin
        if (value[d*BCD_W +: BCD_W] == BCD_NINE) begin
          sum[d*BCD_W +: BCD_W] = '0;
        end else begin
          sum[d*BCD_W +: BCD_W] = value[d*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
    value_nxt_c = clr ? '0 : sum;
    wrap_c      = carry & ~clr;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else begin
      value <= value_nxt_c;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edges, run/step/hold FSM, prescaler, lap freeze, overflow.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned TICK_DIV   = 10,
  parameter int unsigned REPEAT_DLY = 500,
  parameter int unsigned REPEAT_PER = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     inc,
  input  logic                     clr,
  input  logic                     lap,
  output logic                     time_en,
  output logic                     running,
  output logic [BCD_W*DIGITS-1:0]  count,
  output logic [BCD_W*DIGITS-1:0]  disp,
  output logic                     lap_active,
  output logic                     ovf
);

  localparam int unsigned VW = BCD_W * DIGITS;
  localparam int unsigned PW = cnt_w(TICK_DIV);
  localparam int unsigned HW = cnt_w((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);

  state_t          state;
  logic            start_q, stop_q, inc_q, clr_q, lap_q;
  logic [PW-1:0]   presc;
  logic [HW-1:0]   hold_cnt;
  logic            repeat_seen;

  logic            start_e, stop_e, inc_e, clr_e, lap_e;
  logic [HW-1:0]   hold_lim;
  logic            hold_done_c, tick_c, go_step_c, cnt_inc_c, lap_ok_c, wrap_c;
  logic [VW-1:0]   count_nxt_c;

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      {start_q, stop_q, inc_q, clr_q, lap_q} <= '0;
    end else begin
      {start_q, stop_q, inc_q, clr_q, lap_q} <= {start, stop, inc, clr, lap};
    end
  end

  // Event decode: edges, repeat timing, and when the count advances.
  always_comb begin
    start_e     = start & ~start_q;
    stop_e      = stop & ~stop_q;
    inc_e       = inc & ~inc_q;
    clr_e       = clr & ~clr_q;
    lap_e       = lap & ~lap_q;
    hold_lim    = repeat_seen ? HW'(REPEAT_PER - 1) : HW'(REPEAT_DLY - 1);
    hold_done_c = (hold_cnt == hold_lim);
    tick_c      = ~clr_e & (state == ST_RUN) & (presc == PW'(TICK_DIV - 1));
    go_step_c   = 1'b0;
    if (!clr_e && !start_e) begin
      case (state)
        ST_IDLE, ST_PAUSE: go_step_c = inc_e;
        ST_HOLD:           go_step_c = inc & hold_done_c;
        default:           go_step_c = 1'b0;
      endcase
    end
    cnt_inc_c   = tick_c | go_step_c;
    lap_ok_c    = lap_e & ~clr_e & (state == ST_RUN);
  end

  bcd_counter #(.DIGITS(DIGITS)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr_e),
    .inc         (cnt_inc_c),
    .value       (count),
    .value_nxt_c (count_nxt_c),
    .wrap_c      (wrap_c)
  );

  // Mode FSM with registered enables and the auto-repeat hold counter.
  always_ff @(posedge clk) begin
    if (rst || clr_e) begin
      state       <= ST_IDLE;
      time_en     <= 1'b0;
      running     <= 1'b0;
      hold_cnt    <= '0;
      repeat_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (start_e) begin
            state   <= ST_RUN;
            time_en <= 1'b1;
            running <= 1'b1;
          end else if (inc_e) begin
            state   <= ST_STEP;
            time_en <= 1'b1;
            running <= 1'b0;
          end else begin
            time_en <= 1'b0;
            running <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop_e) begin
            state   <= ST_PAUSE;
            time_en <= 1'b0;
            running <= 1'b0;
          end else begin
            time_en <= 1'b1;
            running <= 1'b1;
          end
        end
        ST_STEP: begin
          state    <= ST_HOLD;
          time_en  <= 1'b0;
          running  <= 1'b0;
          hold_cnt <= '0;
        end
        ST_HOLD: begin
          if (start_e) begin
            state    <= ST_RUN;
            time_en  <= 1'b1;
            running  <= 1'b1;
            hold_cnt <= '0;
          end else if (!inc) begin
            state       <= ST_PAUSE;
            time_en     <= 1'b0;
            running     <= 1'b0;
            hold_cnt    <= '0;
            repeat_seen <= 1'b0;
          end else if (hold_done_c) begin
            state       <= ST_STEP;
            time_en     <= 1'b1;
            running     <= 1'b0;
            hold_cnt    <= '0;
            repeat_seen <= 1'b1;
          end else begin
            time_en  <= 1'b0;
            running  <= 1'b0;
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          time_en     <= 1'b0;
          running     <= 1'b0;
          hold_cnt    <= '0;
          repeat_seen <= 1'b0;
        end
      endcase
    end
  end

  // Sub-tick prescaler; only advances in RUN so a resumed run keeps its phase.
  always_ff @(posedge clk) begin
    if (rst || clr_e) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= tick_c ? '0 : presc + PW'(1);
    end
  end

  // Lap freeze of the display value and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || clr_e) begin
      lap_active <= 1'b0;
      disp       <= '0;
      ovf        <= 1'b0;
    end else begin
      ovf <= ovf | wrap_c;
      if (lap_ok_c) begin
        lap_active <= ~lap_active;
        disp       <= lap_active ? count_nxt_c : count;
      end else if (!lap_active) begin
        disp <= count_nxt_c;
      end
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised stopwatch controller with integrated BCD time counter, superseding the plain start/stop/inc enable FSM. It takes debounced, clock-synchronous button levels (start, stop, inc, clr, lap) and produces the count-enable, a live BCD time value and a lap-freezable display value. It sits between the button debouncers and the seven-segment display driver, clocked from the 1000 Hz divided clock.

## Interface
- DIGITS, 4: number of BCD digits in the time value.
- TICK_DIV, 10: clk cycles per count increment while running (1000 Hz / 10 gives 0.01 s resolution); must be ≥ 2.
- REPEAT_DLY, 500: cycles inc must stay held in HOLD before the first auto-repeat step.
- REPEAT_PER, 100: cycles between subsequent auto-repeat steps.
- clk  in  1  system clock (1000 Hz divided clock).
- rst  in  1  reset; synchronous, active-high.
- start, stop, inc, clr, lap  in  1 each  debounced button levels.
- time_en  out  1  high while in RUN or STEP.
- running  out  1  high while in RUN.
- count  out  4*DIGITS  live BCD time, digit 0 in bits [3:0].
- disp  out  4*DIGITS  display value: equals count, or the frozen lap capture.
- lap_active  out  1  disp is frozen.
- ovf  out  1  sticky flag, set when count wraps.

## Operation
- Edge detection: start, stop, clr and lap act on rising edges (registered previous value, reset to 0). inc acts on its rising edge to enter STEP, and on its level in HOLD. A button held through reset therefore produces an edge on the first cycle after reset.
- Event priority: clr > stop > start > inc.
- States: IDLE, RUN, PAUSE, STEP, HOLD. Encodings are a 3-bit localparam set.
- IDLE:
  - start edge goes to RUN.
  - inc edge goes to STEP.
- RUN:
  - stop edge goes to PAUSE.
  - Prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1, count increments and the prescaler returns to 0.
- PAUSE:
  - start edge goes to RUN.
  - inc edge goes to STEP.
  - The prescaler value is held, so a resumed run keeps sub-tick phase.
- STEP (one cycle): count increments by 1, then the FSM goes to HOLD.
- HOLD:
  - inc low goes to PAUSE.
  - start edge goes to RUN.
  - Otherwise a hold counter runs. When it reaches REPEAT_DLY (first repeat) or REPEAT_PER (later repeats), the FSM goes to STEP and the counter restarts. The first-repeat flag clears when HOLD is left via inc low.
- clr edge, in any state: FSM goes to IDLE; count, prescaler, hold counter, lap_active and ovf all clear.
- Lap:
  - A lap edge is accepted only in RUN. It toggles lap_active.
  - On set, disp captures the count value present in that same cycle.
  - While lap_active is high, disp stays frozen in every state until a second lap edge in RUN or a clr.
- Wrap: when count is all 9s and increments, it becomes all 0s and ovf sets. ovf clears only on clr or rst.
- Undefined state encodings recover to IDLE on the next cycle.

## Timing
- All outputs are registered and change one cycle after the causing edge is sampled.
- Reset values: FSM IDLE, time_en=0, running=0, count=0, disp=0, lap_active=0, ovf=0; prescaler and hold counter at 0.
- RUN entry: time_en and running go high the cycle after the start edge. The first count increment comes TICK_DIV cycles after RUN entry from IDLE.
- STEP latency: inc rising edge in cycle n gives count+1 and time_en=1 in cycle n+1, then HOLD with time_en=0 from n+2.
- Auto-repeat: with inc held, steps occur at n+1, n+2+REPEAT_DLY, then every REPEAT_PER+1 cycles.
- Same-cycle start and stop in RUN: stop wins, FSM goes to PAUSE. Same-cycle clr with anything: clr wins.
- Lap edge coinciding with a tick: disp captures the pre-increment count.
- rst mid-RUN or mid-HOLD: all state returns to reset values on the next clock edge.

## Structure
- Shared package/header stopwatch_pkg: state encodings, BCD digit width (4) and the value 4'd9.
- Sub-module bcd_counter:
  - Parameter DIGITS.
  - Inputs clk, rst, clr, inc.
  - Outputs the BCD value and a one-cycle wrap pulse.
  - Ripple-carry per digit, all in one cycle.
- stopwatch_ctrl instantiates one bcd_counter. It contains the FSM, edge detectors, prescaler, hold/repeat counter, lap register and ovf flag.
- Counter widths are $clog2 of the respective parameter.

## Test plan
- Run: reset, start edge, hold 35 cycles, stop edge -> running high then low; count=0x0003; prescaler phase retained. A further start plus 7 cycles gives count=0x0004.
- Step/auto-repeat (REPEAT_DLY=5, REPEAT_PER=3): inc rising from IDLE, held 20 cycles -> steps at cycles 1, 7, 11, 15, 19; count=0x0005; release leads to PAUSE.
- Lap: running with count=0x0012, lap edge -> disp frozen at 0x0012 while count keeps advancing. Second lap edge -> disp tracks count again.
- Wrap (DIGITS=2): preload by stepping to 0x99, then inc edge -> count=0x00, ovf=1. clr -> ovf=0, FSM IDLE.
- Priority: start, stop and clr edges in one cycle during RUN -> IDLE, count=0. Start and stop together in RUN -> PAUSE.
- Reset mid-HOLD with inc still held -> all outputs 0. First cycle after reset sees an inc edge, giving STEP and count=0x0001.
